// File: rtl/hilo_mult_sequencer.sv
// Shift-add multiplier that owns the HI/LO pair and stalls HI/LO readers and new issues until the product lands.
// Optional: define MULT_SKIP_ZERO_EN to short-cut multiplies with a zero operand.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  S_IDLE | waiting for MULT/MULTU; no stall
//  S_BUSY | one radix-2 step per cycle; leaves once cnt reaches WIDTH
//  S_FIX  | apply sign to the product, write hi/lo, pulse done
module hilo_mult_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enhilo_EX,
    input  logic             signed_EX,
    input  logic [WIDTH-1:0] a_EX,
    input  logic [WIDTH-1:0] b_EX,
    input  logic [1:0]       regsel_EX,
    output logic             stall_FETCH,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

    localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(WIDTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;

    // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign a_mag    = (signed_EX && a_EX[WIDTH-1]) ? (~a_EX + ONE_W) : a_EX;
    assign b_mag    = (signed_EX && b_EX[WIDTH-1]) ? (~b_EX + ONE_W) : b_EX;
    assign sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_raw = {acc_q, mplier_q};
    assign prod_fix = neg_q ? (~prod_raw + ONE_2W) : prod_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enhilo_EX) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = signed_EX & (a_EX[WIDTH-1] ^ b_EX[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
`ifdef MULT_SKIP_ZERO_EN
                    // Zero operand: product is known, only the terminal-count cycle and FIX remain.
                    if ((a_EX == '0) || (b_EX == '0)) begin
                        mcand_d  = '0;
                        mplier_d = '0;
                        neg_d    = 1'b0;
                        cnt_d    = CNT_END;
                    end
`endif
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_END) begin
                    state_d = S_FIX;
                end else begin
                    acc_d    = sum[WIDTH:1];
                    mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end
            S_FIX: begin
                hi_d    = prod_fix[2*WIDTH-1:WIDTH];
                lo_d    = prod_fix[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign stall_FETCH = busy & (enhilo_EX | (regsel_EX == 2'd1) | (regsel_EX == 2'd2));
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
